// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared constants and helpers for the debounce bank.
//   DEBOUNCE_DEFAULT_COUNT       : default number of qualified samples per window
//   DEBOUNCE_DEFAULT_SYNC_STAGES : default synchroniser depth
//   debounce_cnt_width(count)    : counter width for a given window, never below 1
// Optional feature macro used by the bank: DEBOUNCE_BANK_SYNC_EN.
// -----------------------------------------------------------------------------
package debounce_pkg;

    localparam int DEBOUNCE_DEFAULT_COUNT       = 512;
    localparam int DEBOUNCE_DEFAULT_SYNC_STAGES = 2;

    // Counter only has to reach COUNT-1, so $clog2(COUNT) bits suffice.
    // COUNT=1 would give zero bits; keep one bit so the vector stays legal.
    function automatic int debounce_cnt_width(input int count);
        int w;
        w = $clog2(count);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debounced input: optional synchroniser, window counter, stable level and
// single-cycle edge pulses.
// Macro DEBOUNCE_BANK_SYNC_EN: when defined, i_in passes through SYNC_STAGES
// flops reset to RESET_LEVEL; when undefined, i_in must already be synchronous.
// Ports:
//   i_clk, i_reset : clock and synchronous active-high reset
//   i_tick         : sample qualifier for the window counter
//   i_in           : raw input
//   o_level        : debounced level
//   o_rise/o_fall  : one-cycle pulse, registered with the level change
//   o_flip         : combinational "level changes at this edge" for the bank OR
// -----------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   COUNT       = DEBOUNCE_DEFAULT_COUNT,
    parameter int   SYNC_STAGES = DEBOUNCE_DEFAULT_SYNC_STAGES,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_tick,
    input  logic i_in,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_flip
);

    localparam int            CW   = debounce_cnt_width(COUNT);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    logic          w_s;
    logic          w_mismatch;
    logic          w_flip;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;

`ifdef DEBOUNCE_BANK_SYNC_EN
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];
`else
    // No synchroniser: SYNC_STAGES has no effect in this build.
    if (SYNC_STAGES < 2) begin : g_sync_stages_ignored
    end

    assign w_s = i_in;
`endif

    assign w_mismatch = (w_s != r_level);
    // Final qualified sample of an uninterrupted mismatching run.
    assign w_flip     = w_mismatch && i_tick && (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_level <= RESET_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (!w_mismatch) begin
                // Any agreeing cycle, ticked or not, restarts the window.
                r_cnt <= '0;
            end else if (i_tick) begin
                if (w_flip) begin
                    r_level <= w_s;
                    r_cnt   <= '0;
                    r_rise  <= w_s;
                    r_fall  <= ~w_s;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_flip  = w_flip;

endmodule

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
// CHANNELS independent debouncers sharing clock, reset and sample tick.
// Macro DEBOUNCE_BANK_SYNC_EN enables the per-channel synchroniser
// (SYNC_STAGES flops); default build has no synchroniser.
// Ports:
//   clk        : sole clock, rising edge
//   reset      : synchronous active-high reset
//   tick       : sample qualifier (tie high to count every clock)
//   in         : raw channel inputs
//   level      : debounced levels
//   rise/fall  : one-cycle edge pulses per channel
//   any_change : OR of all rise/fall, registered alongside them
// -----------------------------------------------------------------------------
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int                  CHANNELS    = 4,
    parameter int                  COUNT       = DEBOUNCE_DEFAULT_COUNT,
    parameter int                  SYNC_STAGES = DEBOUNCE_DEFAULT_SYNC_STAGES,
    parameter logic [CHANNELS-1:0] RESET_LEVEL = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change
);

    logic [CHANNELS-1:0] w_flip;
    logic                r_any_change;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        debounce_channel #(
            .COUNT       (COUNT),
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_LEVEL (RESET_LEVEL[g])
        ) u_chan (
            .i_clk   (clk),
            .i_reset (reset),
            .i_tick  (tick),
            .i_in    (in[g]),
            .o_level (level[g]),
            .o_rise  (rise[g]),
            .o_fall  (fall[g]),
            .o_flip  (w_flip[g])
        );
    end

    // Registered from the same edge events that load rise/fall, so it lines
    // up with them cycle for cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_any_change <= 1'b0;
        end else begin
            r_any_change <= |w_flip;
        end
    end

    assign any_change = r_any_change;

endmodule
